// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters.
//
// The winner's op/operands are registered onto the ALU inputs. The ALU result
// is captured one cycle later and returned over a per-requester valid/ready
// response handshake. Only one operation is in flight at a time.
//
// Ports:
//   clk, reset   - clock; synchronous active-high reset
//   req_valid    - per-requester request valid (2 bits)
//   req_ready    - per-requester accept strobe, only asserted in idle
//   req_op/a/b   - packed per-requester op code and operands
//   resp_valid   - per-requester response valid
//   resp_ready   - per-requester response accept
//   resp_result  - result, qualified by resp_valid
//   resp_err     - unsupported op code flag, qualified by resp_valid
//   alu_op/in1/in2 - registered ALU inputs
//   alu_result   - ALU output, sampled at the end of the execute cycle
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*OPW-1:0]   req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_err,
  output logic [OPW-1:0]     alu_op,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  input  logic [WIDTH-1:0]   alu_result
);

  localparam logic [OPW-1:0] OpAnd = OPW'(0);
  localparam logic [OPW-1:0] OpOr  = OPW'(1);
  localparam logic [OPW-1:0] OpAdd = OPW'(2);
  localparam logic [OPW-1:0] OpSub = OPW'(6);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e             state_q;
  logic               last_grant_q;
  logic               owner_q;
  logic               unsup_q;
  logic [OPW-1:0]     alu_op_q;
  logic [WIDTH-1:0]   alu_in1_q;
  logic [WIDTH-1:0]   alu_in2_q;
  logic [1:0]         resp_valid_q;
  logic [WIDTH-1:0]   resp_result_q;
  logic               resp_err_q;

  logic               grant_idx;
  logic               accept;
  logic [OPW-1:0]     sel_op;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_supported;

  // Grant selection: a lone requester wins; on contention the one that did
  // not win last time wins, so continuous contention alternates strictly.
  always_comb begin
    grant_idx = 1'b0;
    case (req_valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant_q;
      default: grant_idx = 1'b0;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if ((state_q == StIdle) && !reset && (req_valid != 2'b00)) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = (req_ready != 2'b00);

  assign sel_op = grant_idx ? req_op[2*OPW-1:OPW]     : req_op[OPW-1:0];
  assign sel_a  = grant_idx ? req_a[2*WIDTH-1:WIDTH]  : req_a[WIDTH-1:0];
  assign sel_b  = grant_idx ? req_b[2*WIDTH-1:WIDTH]  : req_b[WIDTH-1:0];

  always_comb begin
    sel_supported = 1'b0;
    case (sel_op)
      OpAnd, OpOr, OpAdd, OpSub: sel_supported = 1'b1;
      default:                   sel_supported = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      unsup_q       <= 1'b0;
      alu_op_q      <= OpAdd;
      alu_in1_q     <= '0;
      alu_in2_q     <= '0;
      resp_valid_q  <= 2'b00;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            // Unsupported codes are replaced by ADD so the ALU never sees them.
            alu_op_q     <= sel_supported ? sel_op : OpAdd;
            alu_in1_q    <= sel_a;
            alu_in2_q    <= sel_b;
            unsup_q      <= ~sel_supported;
            owner_q      <= grant_idx;
            last_grant_q <= grant_idx;
            state_q      <= StExec;
          end
        end
        StExec: begin
          resp_result_q <= unsup_q ? '0 : alu_result;
          resp_err_q    <= unsup_q;
          resp_valid_q  <= owner_q ? 2'b10 : 2'b01;
          state_q       <= StResp;
        end
        StResp: begin
          if (resp_ready[owner_q]) begin
            resp_valid_q <= 2'b00;
            resp_err_q   <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;
  assign alu_op      = alu_op_q;
  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table of single-request vectors, a
// scoreboard of expected responses pushed on accept and popped on response
// handshake, and hand-written sequences for contention, backpressure and reset.
module tb_alu_arbiter;

  localparam int W = 32;
  localparam int O = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*O-1:0] req_op;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     resp_valid;
  logic [1:0]     resp_ready;
  logic [W-1:0]   resp_result;
  logic           resp_err;
  logic [O-1:0]   alu_op;
  logic [W-1:0]   alu_in1;
  logic [W-1:0]   alu_in2;
  logic [W-1:0]   alu_result;

  alu_arbiter #(.WIDTH(W), .OPW(O)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .alu_op      (alu_op),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_result  (alu_result)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'b0000: alu_result = alu_in1 & alu_in2;
      4'b0001: alu_result = alu_in1 | alu_in2;
      4'b0010: alu_result = alu_in1 + alu_in2;
      4'b0110: alu_result = alu_in1 - alu_in2;
      default: alu_result = '0;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // {err, result}
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'b0000: model = {1'b0, a & b};
      4'b0001: model = {1'b0, a | b};
      4'b0010: model = {1'b0, a + b};
      4'b0110: model = {1'b0, a - b};
      default: model = {1'b1, 32'h0};
    endcase
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    int          owner;
    logic [31:0] res;
    logic        err;
    int          acc;
  } sb_t;

  sb_t sb_q[$];
  bit  busy_m = 1'b0;
  bit  seen_m = 1'b0;
  int  last_m = 1;

  always @(negedge clk) begin
    if (reset) begin
      chk("ready_in_reset", {62'b0, req_ready}, 64'd0);
      sb_q.delete();
      busy_m = 1'b0;
      seen_m = 1'b0;
      last_m = 1;
    end else begin
      // Accept side first: busy still reflects the previous cycle here.
      if (busy_m) begin
        chk("ready_while_busy", {62'b0, req_ready}, 64'd0);
      end else if (req_valid == 2'b00) begin
        chk("ready_no_req", {62'b0, req_ready}, 64'd0);
      end else begin
        int  g;
        sb_t it;
        logic [32:0] m;
        if (req_valid == 2'b11) g = 1 - last_m;
        else                    g = req_valid[1] ? 1 : 0;
        chk("grant", {62'b0, req_ready}, (g == 1) ? 64'd2 : 64'd1);
        m = model(req_op[g*4 +: 4], req_a[g*32 +: 32], req_b[g*32 +: 32]);
        it.owner = g;
        it.res   = m[31:0];
        it.err   = m[32];
        it.acc   = cyc;
        sb_q.push_back(it);
        busy_m = 1'b1;
        last_m = g;
      end
      // Response side
      if (resp_valid != 2'b00) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", {62'b0, resp_valid}, 64'd0);
        end else begin
          sb_t f;
          f = sb_q[0];
          chk("sb_owner", {62'b0, resp_valid}, (f.owner == 1) ? 64'd2 : 64'd1);
          if (!seen_m) begin
            chk("sb_latency", 64'(cyc - f.acc), 64'd2);
            seen_m = 1'b1;
          end
          if (resp_ready[f.owner]) begin
            chk("sb_result", {32'b0, resp_result}, {32'b0, f.res});
            chk("sb_err", {63'b0, resp_err}, {63'b0, f.err});
            void'(sb_q.pop_front());
            busy_m = 1'b0;
            seen_m = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int          r;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_err;
    logic [3:0]  exp_alu;
  } vec_t;

  vec_t vecs[7];
  int   order[4];

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[r*4 +: 4]  = op;
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_valid[r]      = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset     = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Waits (bounded) for req_ready[r]; leaves the caller at the accept negedge.
  task automatic wait_accept(input int r, input string name);
    int n = 0;
    @(negedge clk);
    while (!req_ready[r] && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[r]) chk({name, "_timeout"}, {62'b0, req_ready}, 64'(1 << r));
  endtask

  task automatic do_one(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    set_req(v.r, v.op, v.a, v.b);
    wait_accept(v.r, nm);
    chk({nm, "_ready"}, {62'b0, req_ready}, 64'(1 << v.r));
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);  // execute cycle
    chk({nm, "_alu_op"}, {60'b0, alu_op}, {60'b0, v.exp_alu});
    chk({nm, "_alu_in1"}, {32'b0, alu_in1}, {32'b0, v.a});
    chk({nm, "_alu_in2"}, {32'b0, alu_in2}, {32'b0, v.b});
    @(negedge clk);  // response cycle, accept + 2
    chk({nm, "_resp_valid"}, {62'b0, resp_valid}, 64'(1 << v.r));
    chk({nm, "_result"}, {32'b0, resp_result}, {32'b0, v.exp_res});
    chk({nm, "_err"}, {63'b0, resp_err}, {63'b0, v.exp_err});
    @(negedge clk);  // back in idle
    chk({nm, "_resp_clr"}, {62'b0, resp_valid}, 64'd0);
    chk({nm, "_err_clr"}, {63'b0, resp_err}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 4'b0010};
    vecs[1] = '{1, 4'b0110, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 4'b0110};
    vecs[2] = '{0, 4'b0000, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1'b0, 4'b0000};
    vecs[3] = '{1, 4'b0001, 32'h1200_0000,  32'h0000_0034,  32'h1200_0034,  1'b0, 4'b0001};
    vecs[4] = '{1, 4'b0011, 32'd5,          32'd6,          32'd0,          1'b1, 4'b0010};
    vecs[5] = '{0, 4'b1111, 32'd9,          32'd9,          32'd0,          1'b1, 4'b0010};
    vecs[6] = '{0, 4'b0010, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0, 4'b0010};

    reset      = 1'b1;
    req_valid  = 2'b01;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {62'b0, req_ready}, 64'd0);
    chk("rst_resp_valid", {62'b0, resp_valid}, 64'd0);
    chk("rst_resp_result", {32'b0, resp_result}, 64'd0);
    chk("rst_resp_err", {63'b0, resp_err}, 64'd0);
    chk("rst_alu_op", {60'b0, alu_op}, 64'd2);
    chk("rst_alu_in1", {32'b0, alu_in1}, 64'd0);
    chk("rst_alu_in2", {32'b0, alu_in2}, 64'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = 2'b00;

    // Single-request vectors
    for (int i = 0; i < 7; i++) do_one(vecs[i], i);

    // Contention: both valid every cycle, grants alternate from 0 after reset
    do_reset();
    resp_ready = 2'b11;
    @(posedge clk); #1;
    set_req(0, 4'b0110, 32'd10, 32'd3);
    set_req(1, 4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
    begin
      int ng = 0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
        @(negedge clk);
        chk("rr_not_both", {63'b0, (req_ready == 2'b11)}, 64'd0);
        if (req_ready != 2'b00) begin
          order[ng] = req_ready[1] ? 1 : 0;
          ng++;
        end
      end
      chk("rr_grant_count", 64'(ng), 64'd4);
      for (int k = 0; k < ng; k++) chk($sformatf("rr_order%0d", k), 64'(order[k]), 64'(k % 2));
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // Backpressure: response held while only the non-owner is ready
    do_reset();
    resp_ready = 2'b10;
    @(posedge clk); #1;
    set_req(0, 4'b0110, 32'd0, 32'd1);
    wait_accept(0, "bp");
    @(posedge clk); #1;
    req_valid = 2'b00;
    set_req(1, 4'b0010, 32'd2, 32'd3);
    @(negedge clk);  // execute
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", k), {62'b0, resp_valid}, 64'd1);
      chk($sformatf("bp_result%0d", k), {32'b0, resp_result}, 64'hFFFF_FFFF);
      chk($sformatf("bp_err%0d", k), {63'b0, resp_err}, 64'd0);
      chk($sformatf("bp_no_ready%0d", k), {62'b0, req_ready}, 64'd0);
    end
    @(posedge clk); #1;
    resp_ready = 2'b01;
    @(negedge clk);  // handshake cycle
    @(negedge clk);
    chk("bp_req1_served", {62'b0, req_ready}, 64'd2);
    @(posedge clk); #1;
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    repeat (4) @(negedge clk);

    // Reset during execute drops the operation
    do_reset();
    resp_ready = 2'b11;
    @(posedge clk); #1;
    set_req(0, 4'b0001, 32'h1, 32'h2);
    wait_accept(0, "rx");
    @(posedge clk); #1;  // now in execute
    req_valid = 2'b00;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rx_resp_valid", {62'b0, resp_valid}, 64'd0);
    chk("rx_resp_result", {32'b0, resp_result}, 64'd0);
    chk("rx_resp_err", {63'b0, resp_err}, 64'd0);
    chk("rx_alu_op", {60'b0, alu_op}, 64'd2);
    chk("rx_alu_in1", {32'b0, alu_in1}, 64'd0);
    chk("rx_alu_in2", {32'b0, alu_in2}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rx_quiet%0d", k), {62'b0, resp_valid}, 64'd0);
    end
    do_one('{0, 4'b0001, 32'h1, 32'h2, 32'd3, 1'b0, 4'b0001}, 99);

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters, for example the execute stage and an address/branch-compare helper.
- Arbitrates round-robin, registers the winner's operands onto the ALU inputs, captures the result, and returns it over a valid/ready response handshake.
- Sits between the requesters and the ALU. It only drives the ALU's op/operand inputs and reads its result.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 4, ALU operation code width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: arbiter accepts requester i this cycle
- req_op  in  2*OPW  op code; requester i at bits [i*OPW +: OPW]
- req_a  in  2*WIDTH  operand In1 per requester, packed the same way
- req_b  in  2*WIDTH  operand In2 per requester, packed the same way
- resp_valid  out  2  bit i: response for requester i is valid
- resp_ready  in  2  bit i: requester i takes its response
- resp_result  out  WIDTH  result, qualified by resp_valid
- resp_err  out  1  op code was unsupported, qualified by resp_valid
- alu_op  out  OPW  to ALU Operation
- alu_in1  out  WIDTH  to ALU In1
- alu_in2  out  WIDTH  to ALU In2
- alu_result  in  WIDTH  from ALU ALU_result

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=1 (so requester 0 wins first).
  - req_ready=0 while reset is high.
  - resp_valid=0, resp_result=0, resp_err=0.
  - alu_op=4'b0010 (ADD), alu_in1=0, alu_in2=0.
- States: IDLE, EXEC, RESP.
- IDLE, grant selection (combinational):
  - Only one req_valid set: that requester is granted.
  - Both set: grant the requester != last_grant.
  - req_ready[g]=1 only in IDLE for granted g; the other bit is 0.
  - req_ready does not depend on resp_ready.
- Accept (IDLE, req_valid[g]=1):
  - Register op/a/b of g into alu_op/alu_in1/alu_in2.
  - owner<=g, last_grant<=g, go to EXEC.
- EXEC (exactly one cycle):
  - alu_* outputs are held stable.
  - At the end of EXEC, capture alu_result into resp_result.
  - Go to RESP; resp_valid[owner]<=1.
- Supported op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- Unsupported op codes:
  - Accepted normally, but alu_op is driven 4'b0010 (ADD) so the ALU never sees an unlisted code.
  - In EXEC, resp_result<=0 and resp_err<=1 instead of capturing alu_result.
- RESP:
  - Hold resp_valid, resp_result and resp_err stable until resp_ready[owner]=1.
  - On that cycle go to IDLE; resp_valid and resp_err clear next cycle.
  - resp_ready of the non-owner is ignored.
- Latency: accept at cycle N, resp_valid at N+2. Minimum issue interval is 3 cycles.
- No new request is accepted before the response is consumed.
- alu_op/alu_in1/alu_in2 keep their last values in RESP and IDLE; they change only on accept.
- Requester must hold req_valid/op/operands until req_ready. The arbiter does not check a withdrawn request.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Reset in EXEC or RESP: the in-flight operation is dropped, no response is issued, and state returns to IDLE next cycle.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH, no carry or overflow output.

Test Plan:
1. Reset, then req_valid=01, op=0010, a=5, b=7, resp_ready=1 -> req_ready=01 at cycle N; resp_valid=01 with resp_result=12 and resp_err=0 at N+2; IDLE at N+3.
2. Both valid every cycle; req0 SUB 10-3, req1 AND 0xF0F0&0x0FF0; resp_ready=11 -> grants in order 0,1,0,1; results 7 and 0x00F0 alternate; req_ready is never 11.
3. req0 op=0110, a=0, b=1, resp_ready held 0 for 5 cycles -> resp_valid=01 with result 0xFFFFFFFF held stable 5 cycles; req1 valid meanwhile gets no req_ready; req1 is served right after the response is consumed.
4. req1 op=0011 (unsupported) -> alu_op=0010 during EXEC; resp_valid=10, resp_err=1, resp_result=0.
5. Assert reset during EXEC of req0 OR 0x1|0x2 -> no resp_valid; all outputs at reset values; next request is served normally with result 3 for the same op.
